trivium_stream_decrypt: RTL

- Receive-side consumer of the Trivium keystream: loads an 80-bit key and IV, runs the 1152-step warm-up, then XORs incoming ciphertext words with keystream to produce plaintext.
- Contains its own 288-bit Trivium state in eSTREAM notation. Ciphertext enters and plaintext leaves on valid/ready streams.
- Sits between the link receiver and the plaintext sink.

---
 rtl/trivium_stream_decrypt.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/trivium_stream_decrypt.sv
// Trivium stream decryptor: loads key/IV, runs the warm-up, then XORs each
// accepted ciphertext word with DATA_W fresh keystream bits.
module trivium_stream_decrypt #(
  parameter int DATA_W = 8,
  parameter int WARMUP = 1152
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [79:0]       key,
  input  logic [79:0]       iv,
  output logic              busy,
  output logic              ks_ready,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  localparam int FILL_W = $clog2(DATA_W + 1);
  localparam logic [10:0]       WARM_LAST = 11'(WARMUP - 1);
  localparam logic [10:0]       WARM_DONE = 11'(WARMUP);
  localparam logic [10:0]       WARM_ONE  = 11'd1;
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(DATA_W - 1);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_FILL   = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  // Bit i of the vector is s(i+1) in eSTREAM notation.
  function automatic logic [287:0] trivium_load(input logic [79:0] k, input logic [79:0] v);
    logic [287:0] s;
    s          = {288{1'b0}};
    s[79:0]    = k;
    s[172:93]  = v;
    s[287:285] = 3'b111;
    return s;
  endfunction

  // Returns {z, next_state} for one Trivium step.
  function automatic logic [288:0] trivium_step(input logic [287:0] s);
    logic t1, t2, t3, z;
    t1 = s[65] ^ s[92];
    t2 = s[161] ^ s[176];
    t3 = s[242] ^ s[287];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (s[90] & s[91]) ^ s[170];
    t2 = t2 ^ (s[174] & s[175]) ^ s[263];
    t3 = t3 ^ (s[285] & s[286]) ^ s[68];
    return {z, s[286:177], t2, s[175:93], t1, s[91:0], t3};
  endfunction

  state_t              st_r;
  logic [287:0]        s_r;
  logic [10:0]         warm_cnt_r;
  logic [FILL_W-1:0]   fill_cnt_r;
  logic [DATA_W-1:0]   ks_buf_r;
  logic                busy_r;
  logic                ks_ready_r;
  logic                out_valid_r;
  logic [DATA_W-1:0]   out_data_r;

  logic [288:0]        step_s;
  logic                z_s;
  logic [287:0]        next_s;
  logic                in_ready_s;
  logic                accept_s;

  assign step_s     = trivium_step(s_r);
  assign z_s        = step_s[288];
  assign next_s     = step_s[287:0];
  // A start in the same cycle always wins over a ciphertext accept.
  assign in_ready_s = (st_r == ST_RUN) & ~start & (~out_valid_r | out_ready);
  assign accept_s   = in_valid & in_ready_s;

  // Control FSM, Trivium state, keystream buffer and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_r        <= ST_IDLE;
      s_r         <= {288{1'b0}};
      warm_cnt_r  <= 11'd0;
      fill_cnt_r  <= {FILL_W{1'b0}};
      ks_buf_r    <= {DATA_W{1'b0}};
      busy_r      <= 1'b0;
      ks_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_W{1'b0}};
    end else if (start) begin
      st_r        <= ST_WARMUP;
      s_r         <= trivium_load(key, iv);
      warm_cnt_r  <= 11'd0;
      fill_cnt_r  <= {FILL_W{1'b0}};
      ks_buf_r    <= {DATA_W{1'b0}};
      busy_r      <= 1'b1;
      ks_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      if (out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
      end
      case (st_r)
        ST_IDLE: begin
          st_r <= ST_IDLE;
        end
        ST_WARMUP: begin
          s_r <= next_s;
          if (warm_cnt_r == WARM_LAST) begin
            warm_cnt_r <= WARM_DONE;
            fill_cnt_r <= {FILL_W{1'b0}};
            st_r       <= ST_FILL;
          end else begin
            warm_cnt_r <= warm_cnt_r + WARM_ONE;
          end
        end
        ST_FILL: begin
          s_r        <= next_s;
          ks_buf_r   <= {z_s, ks_buf_r[DATA_W-1:1]};
          fill_cnt_r <= fill_cnt_r + FILL_ONE;
          if (fill_cnt_r == FILL_LAST) begin
            st_r       <= ST_RUN;
            busy_r     <= 1'b0;
            ks_ready_r <= 1'b1;
          end
        end
        ST_RUN: begin
          // Buffer is full here, so the cipher only advances after an accept.
          if (accept_s) begin
            out_data_r  <= in_data ^ ks_buf_r;
            out_valid_r <= 1'b1;
            fill_cnt_r  <= {FILL_W{1'b0}};
            st_r        <= ST_FILL;
            busy_r      <= 1'b1;
            ks_ready_r  <= 1'b0;
          end
        end
        default: begin
          st_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign ks_ready  = ks_ready_r;
  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

endmodule
